flash_loader: RTL and testbench
===============================

Name: flash_loader

Overview:
- Host-side master for the flash memory interface. Drives the `Enable_n`/`REQ_n` handshake toward the SPI flash device block.
- Copies a block of LENGTH bytes, starting at flash address SRC_ADDR, into a byte-wide memory write port starting at DST_ADDR.
- Used at boot and on demand to load ROM images from SPI flash into cartridge RAM.
- Controlled by a START pulse; reports BUSY and a one-cycle DONE.

Parameters:
- ADDR_WIDTH, 24, flash byte address width; must match the flash interface instance.
- MEM_ADDR_WIDTH, 16, destination memory address width.
- LEN_WIDTH, 16, width of the byte count.

Ports:
- CLK  input  1  drive clock.
- RESET_n  input  1  reset, asynchronous, active-low.
- START  input  1  one-cycle request; sampled only in IDLE.
- SRC_ADDR  input  ADDR_WIDTH  flash start address; latched on accepted START.
- DST_ADDR  input  MEM_ADDR_WIDTH  memory start address; latched on accepted START.
- LENGTH  input  LEN_WIDTH  byte count; latched on accepted START.
- BUSY  output  1  high from accepted START until DONE.
- DONE  output  1  one-cycle pulse at completion.
- MEM_ADDR  output  MEM_ADDR_WIDTH  write address.
- MEM_DATA  output  8  write data.
- MEM_WE  output  1  write request; held until MEM_ACK.
- MEM_ACK  input  1  write accepted in this cycle.
- Flash  modport HOST  interface  `Address`/`Mode`/`Enable_n`/`REQ_n` out; `ACK_n`/`Data` in.

Behaviour:
- Reset values:
  - `Flash.Enable_n`=1, `Flash.REQ_n`=1, `Flash.Address`=0, `Flash.Mode`=FLASH_MODE_READ.
  - BUSY=0, DONE=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, state=IDLE, byte counter=0.
- Reset mid-operation returns everything to reset values immediately. `Enable_n`=1 makes the flash device abandon its transfer and release CS.
- IDLE:
  - START=1 with LENGTH!=0: latch inputs, `Flash.Address`<=SRC_ADDR, `Enable_n`<=0, BUSY<=1, go to OPEN_ACK.
  - START=1 with LENGTH=0: DONE=1 on the next cycle; BUSY and `Enable_n` are never asserted.
- START while BUSY is ignored; latched values do not change.
- OPEN_ACK: wait for `ACK_n`=0 (command accepted), then go to OPEN_READY.
- OPEN_READY: wait for `ACK_n`=1 (read command plus address shifted out), then go to REQ.
- REQ: drive `REQ_n`=0. On `ACK_n`=0, drive `REQ_n`<=1 and go to DATA.
  - `REQ_n` must be high before the device can return `ACK_n`=1. Otherwise the device starts an unwanted extra byte.
- DATA: on `ACK_n`=1, latch `Flash.Data` into MEM_DATA (valid in the same cycle), MEM_WE<=1, go to WRITE.
- WRITE:
  - Hold MEM_WE, MEM_ADDR and MEM_DATA stable until MEM_ACK=1. In the MEM_ACK cycle: MEM_WE<=0, MEM_ADDR+1, counter+1.
  - If counter+1==LENGTH, go to CLOSE. Otherwise go to REQ.
  - MEM_ACK may arrive in the first MEM_WE cycle (one-cycle write).
- CLOSE: `Enable_n`<=1, BUSY<=0, DONE<=1 for one cycle, return to IDLE.
- Sequential read: `Flash.Address` is not updated per byte; the device streams sequential bytes after one command.
- Wrap-around:
  - MEM_ADDR wraps modulo 2^MEM_ADDR_WIDTH silently.
  - LENGTH=2^LEN_WIDTH-1 is the maximum transfer.
- `Enable_n` stays low continuously between OPEN_ACK and CLOSE.
- Latency from accepted START to first MEM_WE is 4 cycles plus device command time. Per byte: 3 cycles plus SPI byte time plus memory wait.

Optional Feature:
- Macro FLASH_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output CHECKSUM [15:0], cleared on accepted START.
  - Adds each written byte (zero-extended, modulo 2^16) in its MEM_ACK cycle.
  - Value is final and stable when DONE pulses, and held until the next START.
  - Reset value is 0.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- SRC_ADDR=24'h012345, DST_ADDR=16'h4000, LENGTH=4, flash model bytes AA,55,01,FF, MEM_ACK tied 1 ->
  - one read command with address 012345 only.
  - writes 4000=AA, 4001=55, 4002=01, 4003=FF.
  - DONE one cycle; BUSY low after; `Enable_n` high.
- LENGTH=0 -> DONE one cycle later; `Enable_n`, BUSY and MEM_WE never asserted.
- LENGTH=3, MEM_ACK delayed 5 cycles per write -> MEM_WE, MEM_ADDR and MEM_DATA stable throughout; no `REQ_n` low during a pending write; exactly 3 SPI data bytes.
- RESET_n pulled low during byte 2 of LENGTH=8 -> all outputs return to reset values asynchronously; after release a new START (LENGTH=1) completes normally.
- START pulsed again while BUSY with different SRC_ADDR -> ignored; original transfer completes with original addresses.
- FLASH_LOADER_CHECKSUM_EN defined, bytes 80,80,01 -> CHECKSUM=16'h0101 at DONE.

Source files
------------

// File: rtl/flash_loader_if.sv
// Flash interface: mode constants and the host/device bus between the loader
// and the SPI flash device block.
package flash_pkg;
  localparam logic [1:0] FLASH_MODE_READ  = 2'd0;
  localparam logic [1:0] FLASH_MODE_WRITE = 2'd1;
  localparam logic [1:0] FLASH_MODE_ERASE = 2'd2;
endpackage

interface flash_if #(
  parameter int ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] Address;
  logic [1:0]            Mode;
  logic                  Enable_n;
  logic                  REQ_n;
  logic                  ACK_n;
  logic [7:0]            Data;

  modport HOST (
    output Address, Mode, Enable_n, REQ_n,
    input  ACK_n, Data
  );

  modport DEVICE (
    input  Address, Mode, Enable_n, REQ_n,
    output ACK_n, Data
  );
endinterface

// File: rtl/flash_loader.sv
// Copies LENGTH bytes from SPI flash (one sequential read command) into a byte-wide
// memory write port. Optional FLASH_LOADER_CHECKSUM_EN adds a 16-bit byte-sum output.
module flash_loader
  import flash_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  input  logic                      START,
  input  logic [ADDR_WIDTH-1:0]     SRC_ADDR,
  input  logic [MEM_ADDR_WIDTH-1:0] DST_ADDR,
  input  logic [LEN_WIDTH-1:0]      LENGTH,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [7:0]                MEM_DATA,
  output logic                      MEM_WE,
  input  logic                      MEM_ACK,
`ifdef FLASH_LOADER_CHECKSUM_EN
  output logic [15:0]               CHECKSUM,
`endif
  flash_if.HOST                     Flash
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN_ACK,
    S_OPEN_READY,
    S_REQ,
    S_DATA,
    S_WRITE,
    S_CLOSE
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      count_q, count_d, count_inc;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]                mem_data_q, mem_data_d;
  logic                      mem_we_q, mem_we_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      enable_n_q, enable_n_d;
  logic                      req_n_q, req_n_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [15:0]               checksum_q, checksum_d;
`endif

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      enable_n_q <= 1'b1;
      req_n_q    <= 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      enable_n_q <= enable_n_d;
      req_n_q    <= req_n_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  // REQ_n is lowered on the transition into S_REQ and raised as soon as the device
  // acknowledges, so it is already high before the device can finish the byte.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = mem_we_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    enable_n_d = enable_n_q;
    req_n_d    = req_n_q;
    count_inc  = count_q + 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (START) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
          if (LENGTH != '0) begin
            addr_d     = SRC_ADDR;
            mem_addr_d = DST_ADDR;
            len_d      = LENGTH;
            count_d    = '0;
            enable_n_d = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_OPEN_ACK;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_OPEN_ACK: begin
        if (!Flash.ACK_n) begin
          state_d = S_OPEN_READY;
        end
      end

      S_OPEN_READY: begin
        if (Flash.ACK_n) begin
          req_n_d = 1'b0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (!Flash.ACK_n) begin
          req_n_d = 1'b1;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (Flash.ACK_n) begin
          mem_data_d = Flash.Data;
          mem_we_d   = 1'b1;
          state_d    = S_WRITE;
        end
      end

      // Address, data and write strobe stay frozen until the memory accepts the byte.
      S_WRITE: begin
        if (MEM_ACK) begin
          mem_we_d   = 1'b0;
          mem_addr_d = mem_addr_q + 1'b1;
          count_d    = count_inc;
`ifdef FLASH_LOADER_CHECKSUM_EN
          checksum_d = checksum_q + {8'h00, mem_data_q};
`endif
          if (count_inc == len_q) begin
            state_d = S_CLOSE;
          end else begin
            req_n_d = 1'b0;
            state_d = S_REQ;
          end
        end
      end

      S_CLOSE: begin
        enable_n_d = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign MEM_ADDR      = mem_addr_q;
  assign MEM_DATA      = mem_data_q;
  assign MEM_WE        = mem_we_q;
  assign Flash.Address = addr_q;
  assign Flash.Mode    = FLASH_MODE_READ;
  assign Flash.Enable_n = enable_n_q;
  assign Flash.REQ_n   = req_n_q;
`ifdef FLASH_LOADER_CHECKSUM_EN
  assign CHECKSUM      = checksum_q;
`endif

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: behavioural SPI flash device, memory with
// programmable ack delay, table-driven and randomized transfers plus corner sequences.
module tb_flash_loader;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        START;
  logic [23:0] SRC_ADDR;
  logic [15:0] DST_ADDR;
  logic [15:0] LENGTH;
  logic        BUSY;
  logic        DONE;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        MEM_WE;
  logic        MEM_ACK;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [15:0] CHECKSUM;
`endif

  flash_if #(.ADDR_WIDTH(24)) flash_bus ();

  flash_loader #(
    .ADDR_WIDTH(24),
    .MEM_ADDR_WIDTH(16),
    .LEN_WIDTH(16)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .START(START),
    .SRC_ADDR(SRC_ADDR),
    .DST_ADDR(DST_ADDR),
    .LENGTH(LENGTH),
    .BUSY(BUSY),
    .DONE(DONE),
    .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA),
    .MEM_WE(MEM_WE),
    .MEM_ACK(MEM_ACK),
`ifdef FLASH_LOADER_CHECKSUM_EN
    .CHECKSUM(CHECKSUM),
`endif
    .Flash(flash_bus)
  );

  always #5 CLK = ~CLK;

  int tests_run    = 0;
  int tests_failed = 0;

  // Environment configuration, written only by the test sequence.
  int         ack_delay = 0;
  int         byte_time = 2;
  int         cmd_time  = 2;
  logic [7:0] stream [256];

  // Observations, written only by the environment process.
  int          cmd_count = 0;
  logic [23:0] cmd_addr  = '0;
  int          bytes_served = 0;
  int          req_overlap = 0;
  int          unstable = 0;
  int          req_during_write = 0;
  int          done_cnt = 0;
  int          active_seen = 0;
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];

  int          dev_state = 0;
  int          dev_timer = 0;
  int          stream_idx = 0;
  int          we_cnt = 0;
  logic [15:0] hold_addr;
  logic [7:0]  hold_data;

  // Device and memory models react on the falling edge, away from the DUT's edge.
  always @(negedge CLK) begin
    if (!RESET_n) begin
      dev_state = 0;
      flash_bus.ACK_n = 1'b1;
      MEM_ACK = 1'b0;
      we_cnt = 0;
    end else begin
      if (DONE) done_cnt++;
      if (BUSY || !flash_bus.Enable_n || MEM_WE) active_seen++;
      if (MEM_WE && !flash_bus.REQ_n) req_during_write++;

      if (MEM_WE) begin
        if (we_cnt == 0) begin
          hold_addr = MEM_ADDR;
          hold_data = MEM_DATA;
        end else if (MEM_ADDR != hold_addr || MEM_DATA != hold_data) begin
          unstable++;
        end
        if (we_cnt >= ack_delay) begin
          MEM_ACK = 1'b1;
          wr_addr_q.push_back(MEM_ADDR);
          wr_data_q.push_back(MEM_DATA);
          we_cnt = 0;
        end else begin
          MEM_ACK = 1'b0;
          we_cnt++;
        end
      end else begin
        MEM_ACK = 1'b0;
        we_cnt = 0;
      end

      if (flash_bus.Enable_n) begin
        dev_state = 0;
        flash_bus.ACK_n = 1'b1;
      end else begin
        case (dev_state)
          0: begin
            cmd_count++;
            cmd_addr = flash_bus.Address;
            stream_idx = 0;
            dev_timer = 1;
            dev_state = 1;
          end
          1: begin
            if (dev_timer == 0) begin
              flash_bus.ACK_n = 1'b0;
              dev_timer = cmd_time;
              dev_state = 2;
            end else dev_timer--;
          end
          2: begin
            if (dev_timer == 0) begin
              flash_bus.ACK_n = 1'b1;
              dev_state = 3;
            end else dev_timer--;
          end
          3: begin
            if (!flash_bus.REQ_n) begin
              flash_bus.ACK_n = 1'b0;
              dev_timer = byte_time;
              dev_state = 4;
            end
          end
          default: begin
            if (dev_timer == 0) begin
              if (!flash_bus.REQ_n) req_overlap++;
              flash_bus.Data = stream[stream_idx & 255];
              stream_idx++;
              bytes_served++;
              flash_bus.ACK_n = 1'b1;
              dev_state = 3;
            end else dev_timer--;
          end
        endcase
      end
    end
  end

  typedef struct {
    logic [23:0] src;
    logic [15:0] dst;
    int          len;
    int          ackd;
    int          bt;
    int          ct;
    int          exp_writes;
    logic [15:0] exp_end;
  } vec_t;

  vec_t vecs [6];

  int base_wr, base_cmd, base_bytes, base_overlap, base_unstable, base_rdw, base_done, base_active;
  logic [15:0] cs_at_done;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic snap();
    base_wr       = wr_addr_q.size();
    base_cmd      = cmd_count;
    base_bytes    = bytes_served;
    base_overlap  = req_overlap;
    base_unstable = unstable;
    base_rdw      = req_during_write;
    base_done     = done_cnt;
    base_active   = active_seen;
  endtask

  task automatic applyStimulus(input logic [23:0] src, input logic [15:0] dst, input logic [15:0] len);
    @(negedge CLK);
    SRC_ADDR = src;
    DST_ADDR = dst;
    LENGTH   = len;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;
    SRC_ADDR = 24'($urandom);
    DST_ADDR = 16'($urandom);
    LENGTH   = 16'($urandom);
  endtask

  task automatic startTransfer(input logic [23:0] src, input logic [15:0] dst, input int len,
                               input int ackd, input int bt, input int ct);
    ack_delay = ackd;
    byte_time = bt;
    cmd_time  = ct;
    snap();
    applyStimulus(src, dst, 16'(len));
  endtask

  task automatic finishTransfer(input string tag, input logic [23:0] src, input logic [15:0] dst,
                                input int len, input int exp_writes, input logic [15:0] exp_end);
    bit timed_out;
    int got;
    logic [15:0] exp_cs;
    timed_out = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (DONE === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge CLK);
    end
    checkOutput({tag, " done_timeout"}, 64'(timed_out), 64'd0);
    if (!timed_out) begin
      checkOutput({tag, " busy_at_done"}, 64'(BUSY), 64'd0);
      checkOutput({tag, " enable_n_at_done"}, 64'(flash_bus.Enable_n), 64'd1);
`ifdef FLASH_LOADER_CHECKSUM_EN
      cs_at_done = CHECKSUM;
`endif
      @(negedge CLK);
      checkOutput({tag, " done_after"}, 64'(DONE), 64'd0);
    end
    repeat (3) @(negedge CLK);

    checkOutput({tag, " done_pulses"}, 64'(done_cnt - base_done), 64'd1);
    got = wr_addr_q.size() - base_wr;
    checkOutput({tag, " write_count"}, 64'(got), 64'(exp_writes));
    exp_cs = '0;
    for (int i = 0; i < len; i++) exp_cs = exp_cs + {8'h00, stream[i & 255]};
    for (int i = 0; i < got && i < len; i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(wr_addr_q[base_wr + i]), 64'(16'(dst + 16'(i))));
      checkOutput($sformatf("%s data[%0d]", tag, i), 64'(wr_data_q[base_wr + i]), 64'(stream[i & 255]));
    end
    if (len > 0) begin
      checkOutput({tag, " commands"}, 64'(cmd_count - base_cmd), 64'd1);
      checkOutput({tag, " cmd_addr"}, 64'(cmd_addr), 64'(src));
      checkOutput({tag, " spi_bytes"}, 64'(bytes_served - base_bytes), 64'(len));
      checkOutput({tag, " end_addr"}, 64'(MEM_ADDR), 64'(exp_end));
    end else begin
      checkOutput({tag, " commands"}, 64'(cmd_count - base_cmd), 64'd0);
      checkOutput({tag, " activity"}, 64'(active_seen - base_active), 64'd0);
    end
    checkOutput({tag, " req_overlap"}, 64'(req_overlap - base_overlap), 64'd0);
    checkOutput({tag, " write_stable"}, 64'(unstable - base_unstable), 64'd0);
    checkOutput({tag, " req_during_write"}, 64'(req_during_write - base_rdw), 64'd0);
    checkOutput({tag, " busy_after"}, 64'(BUSY), 64'd0);
    checkOutput({tag, " enable_n_after"}, 64'(flash_bus.Enable_n), 64'd1);
`ifdef FLASH_LOADER_CHECKSUM_EN
    if (!timed_out) checkOutput({tag, " checksum"}, 64'(cs_at_done), 64'(exp_cs));
    checkOutput({tag, " checksum_held"}, 64'(CHECKSUM), 64'(exp_cs));
`endif
  endtask

  initial begin
    logic [23:0] rsrc;
    logic [15:0] rdst;
    int          rlen;
    bit          waited_out;

    RESET_n  = 1'b0;
    START    = 1'b0;
    SRC_ADDR = '0;
    DST_ADDR = '0;
    LENGTH   = '0;

    vecs[0] = '{24'h012345, 16'h4000, 4, 0, 2, 3, 4, 16'h4004};
    vecs[1] = '{24'h000000, 16'h0000, 0, 0, 2, 3, 0, 16'h0000};
    vecs[2] = '{24'h000100, 16'h1234, 3, 5, 2, 3, 3, 16'h1237};
    vecs[3] = '{24'hFFFFF0, 16'hFFFE, 4, 1, 1, 2, 4, 16'h0002};
    vecs[4] = '{24'h7ABCDE, 16'h8000, 1, 0, 0, 0, 1, 16'h8001};
    vecs[5] = '{24'h000000, 16'h00FF, 6, 2, 3, 4, 6, 16'h0105};

    repeat (3) @(negedge CLK);
    checkOutput("reset BUSY", 64'(BUSY), 64'd0);
    checkOutput("reset DONE", 64'(DONE), 64'd0);
    checkOutput("reset MEM_WE", 64'(MEM_WE), 64'd0);
    checkOutput("reset MEM_ADDR", 64'(MEM_ADDR), 64'd0);
    checkOutput("reset MEM_DATA", 64'(MEM_DATA), 64'd0);
    checkOutput("reset Enable_n", 64'(flash_bus.Enable_n), 64'd1);
    checkOutput("reset REQ_n", 64'(flash_bus.REQ_n), 64'd1);
    checkOutput("reset Address", 64'(flash_bus.Address), 64'd0);
    checkOutput("reset Mode", 64'(flash_bus.Mode), 64'(flash_pkg::FLASH_MODE_READ));
`ifdef FLASH_LOADER_CHECKSUM_EN
    checkOutput("reset CHECKSUM", 64'(CHECKSUM), 64'd0);
`endif
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 256; i++) stream[i] = 8'($urandom);
    stream[0] = 8'hAA;
    stream[1] = 8'h55;
    stream[2] = 8'h01;
    stream[3] = 8'hFF;

    for (int v = 0; v < 6; v++) begin
      startTransfer(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].ackd, vecs[v].bt, vecs[v].ct);
      finishTransfer($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
                     vecs[v].exp_writes, vecs[v].exp_end);
    end

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) stream[i] = 8'($urandom);
      rsrc = 24'($urandom);
      rdst = 16'($urandom);
      rlen = int'($urandom_range(24, 1));
      startTransfer(rsrc, rdst, rlen, int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
                    int'($urandom_range(4, 0)));
      finishTransfer($sformatf("rand%0d", r), rsrc, rdst, rlen, rlen, 16'(rdst + 16'(rlen)));
    end

    // START pulsed mid-transfer with other parameters must leave the transfer untouched.
    startTransfer(24'h135790, 16'h2000, 5, 1, 3, 2);
    repeat (3) @(negedge CLK);
    applyStimulus(24'h00ABCD, 16'h9000, 16'd2);
    finishTransfer("busy_start", 24'h135790, 16'h2000, 5, 5, 16'h2005);

    // Asynchronous reset while byte 2 of an 8-byte transfer is in flight.
    startTransfer(24'h0C0FFE, 16'h3000, 8, 0, 3, 2);
    waited_out = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (wr_addr_q.size() > base_wr) begin
        waited_out = 1'b0;
        break;
      end
      @(negedge CLK);
    end
    checkOutput("midreset first_byte_timeout", 64'(waited_out), 64'd0);
    repeat (3) @(negedge CLK);
    #2 RESET_n = 1'b0;
    #1;
    checkOutput("midreset BUSY", 64'(BUSY), 64'd0);
    checkOutput("midreset MEM_WE", 64'(MEM_WE), 64'd0);
    checkOutput("midreset MEM_ADDR", 64'(MEM_ADDR), 64'd0);
    checkOutput("midreset MEM_DATA", 64'(MEM_DATA), 64'd0);
    checkOutput("midreset Enable_n", 64'(flash_bus.Enable_n), 64'd1);
    checkOutput("midreset REQ_n", 64'(flash_bus.REQ_n), 64'd1);
    checkOutput("midreset Address", 64'(flash_bus.Address), 64'd0);
`ifdef FLASH_LOADER_CHECKSUM_EN
    checkOutput("midreset CHECKSUM", 64'(CHECKSUM), 64'd0);
`endif
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);
    startTransfer(24'h0000A5, 16'h5000, 1, 0, 2, 2);
    finishTransfer("after_reset", 24'h0000A5, 16'h5000, 1, 1, 16'h5001);

`ifdef FLASH_LOADER_CHECKSUM_EN
    stream[0] = 8'h80;
    stream[1] = 8'h80;
    stream[2] = 8'h01;
    startTransfer(24'h000010, 16'h6000, 3, 0, 2, 2);
    finishTransfer("checksum_run", 24'h000010, 16'h6000, 3, 3, 16'h6003);
    checkOutput("checksum_plan", 64'(cs_at_done), 64'h0101);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
